// File: rtl/alu_pkg.sv
// Shared types for alu_seq: opcodes, FSM states, shift kinds and the flag bundle.
package alu_pkg;

    typedef enum logic [3:0] {
        OP_ADD = 4'd0,
        OP_SUB = 4'd1,
        OP_ADC = 4'd2,
        OP_SBC = 4'd3,
        OP_AND = 4'd4,
        OP_OR  = 4'd5,
        OP_XOR = 4'd6,
        OP_SLL = 4'd7,
        OP_SRL = 4'd8,
        OP_SRA = 4'd9
    } op_e;

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_e;

    typedef enum logic [1:0] {
        SH_SLL,
        SH_SRL,
        SH_SRA
    } shkind_e;

    typedef struct packed {
        logic c;
        logic v;
        logic z;
        logic n;
    } flags_t;

    function automatic logic is_shift_op(input logic [3:0] op);
        return (op == OP_SLL) || (op == OP_SRL) || (op == OP_SRA);
    endfunction

    function automatic shkind_e shkind_of(input logic [3:0] op);
        if (op == OP_SLL) return SH_SLL;
        if (op == OP_SRL) return SH_SRL;
        return SH_SRA;
    endfunction

endpackage

// File: rtl/alu_seq_shifter.sv
// Shift datapath for alu_seq: iterative 1 bit/cycle by default, single-cycle barrel
// shifter when ALU_SEQ_BARREL_EN is defined. done marks the cycle res/c are final.
module alu_seq_shifter
    import alu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               start,
    input  shkind_e            kind,
    input  logic [XLEN-1:0]    a,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               done,
    output logic [XLEN-1:0]    res,
    output logic               c
);

`ifdef ALU_SEQ_BARREL_EN

    logic [SHAMT_W-1:0] out_idx;

    always_comb begin
        out_idx = shamt - 1'b1;
        res     = a << shamt;
        if (kind == SH_SRL) begin
            res = a >> shamt;
        end else if (kind == SH_SRA) begin
            res = XLEN'($signed(a) >>> shamt);
        end
        // Left shifts lose bit XLEN-shamt last, which is -shamt modulo XLEN.
        if (kind == SH_SLL) begin
            out_idx = '0 - shamt;
        end
        c    = (shamt == '0) ? 1'b0 : a[out_idx];
        done = start;
    end

`else

    logic [XLEN-1:0]    val_q;
    logic [SHAMT_W-1:0] cnt_q;
    shkind_e            kind_q;
    logic               busy_q;
    logic [XLEN-1:0]    step;
    logic               step_c;

    always_comb begin
        step   = {val_q[XLEN-2:0], 1'b0};
        step_c = val_q[XLEN-1];
        if (kind_q == SH_SRL) begin
            step   = {1'b0, val_q[XLEN-1:1]};
            step_c = val_q[0];
        end else if (kind_q == SH_SRA) begin
            step   = {val_q[XLEN-1], val_q[XLEN-1:1]};
            step_c = val_q[0];
        end
        // A zero-amount shift finishes in the start cycle with the operand untouched.
        done = (start && (shamt == '0)) || (busy_q && (cnt_q == SHAMT_W'(1)));
        res  = start ? a : step;
        c    = start ? 1'b0 : step_c;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            val_q  <= '0;
            cnt_q  <= '0;
            kind_q <= SH_SLL;
            busy_q <= 1'b0;
        end else if (start && (shamt != '0)) begin
            val_q  <= a;
            cnt_q  <= shamt;
            kind_q <= kind;
            busy_q <= 1'b1;
        end else if (busy_q) begin
            val_q <= step;
            cnt_q <= cnt_q - 1'b1;
            if (cnt_q == SHAMT_W'(1)) begin
                busy_q <= 1'b0;
            end
        end
    end

`endif

endmodule

// File: rtl/alu_seq.sv
// Handshaked ALU with registered result/flags; 1-cycle ops, shifts take 1+shamt cycles
// (1 cycle with ALU_SEQ_BARREL_EN). Result held in DONE until res_ready_i.
module alu_seq
    import alu_pkg::*;
#(
    parameter int XLEN    = 64,
    parameter int SHAMT_W = $clog2(XLEN)
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            in_valid_i,
    output logic            in_ready_o,
    input  logic [3:0]      op_i,
    input  logic [XLEN-1:0] a_i,
    input  logic [XLEN-1:0] b_i,
    input  logic            cflag_i,
    output logic            res_valid_o,
    input  logic            res_ready_i,
    output logic [XLEN-1:0] out_o,
    output logic            cflag_o,
    output logic            vflag_o,
    output logic            zflag_o,
    output logic            nflag_o,
    output logic            illegal_o
);

    state_e          state;
    logic            in_ready_q;
    logic            res_valid_q;
    logic [XLEN-1:0] out_q;
    flags_t          flags_q;
    logic            illegal_q;

    logic [XLEN-1:0] b_eff;
    logic            cin;
    logic [XLEN:0]   sum;
    logic [XLEN-1:0] nxt_res;
    logic            nxt_c;
    logic            nxt_v;
    logic            nxt_ill;
    flags_t          nxt_flags;
    logic            accept;
    logic            sh_start;
    logic            sh_done;
    logic [XLEN-1:0] sh_res;
    logic            sh_c;
    logic            load;

    assign accept   = (state == S_IDLE) && in_valid_i && in_ready_q;
    assign sh_start = accept && is_shift_op(op_i);

    alu_seq_shifter #(
        .XLEN    (XLEN),
        .SHAMT_W (SHAMT_W)
    ) u_shifter (
        .clk   (clk_i),
        .rst_n (rst_ni),
        .start (sh_start),
        .kind  (shkind_of(op_i)),
        .a     (a_i),
        .shamt (b_i[SHAMT_W-1:0]),
        .done  (sh_done),
        .res   (sh_res),
        .c     (sh_c)
    );

    always_comb begin
        b_eff = b_i;
        cin   = 1'b0;
        case (op_i)
            OP_SUB: begin b_eff = ~b_i; cin = 1'b1;    end
            OP_ADC: begin               cin = cflag_i; end
            OP_SBC: begin b_eff = ~b_i; cin = cflag_i; end
            default: ;
        endcase
        sum = {1'b0, a_i} + {1'b0, b_eff} + {{XLEN{1'b0}}, cin};

        nxt_res = '0;
        nxt_c   = 1'b0;
        nxt_v   = 1'b0;
        nxt_ill = 1'b0;
        // While shifting, op_i no longer describes the operation in flight.
        if (state == S_SHIFT) begin
            nxt_res = sh_res;
            nxt_c   = sh_c;
        end else begin
            case (op_i)
                OP_ADD, OP_SUB, OP_ADC, OP_SBC: begin
                    nxt_res = sum[XLEN-1:0];
                    nxt_c   = sum[XLEN];
                    nxt_v   = a_i[XLEN-1] ^ b_eff[XLEN-1] ^ sum[XLEN-1] ^ sum[XLEN];
                end
                OP_AND: nxt_res = a_i & b_i;
                OP_OR:  nxt_res = a_i | b_i;
                OP_XOR: nxt_res = a_i ^ b_i;
                OP_SLL, OP_SRL, OP_SRA: begin
                    nxt_res = sh_res;
                    nxt_c   = sh_c;
                end
                default: nxt_ill = 1'b1;
            endcase
        end
        nxt_flags = '{c: nxt_c, v: nxt_v, z: (nxt_res == '0), n: nxt_res[XLEN-1]};

        load = (accept && (!is_shift_op(op_i) || sh_done)) || ((state == S_SHIFT) && sh_done);
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state       <= S_IDLE;
            in_ready_q  <= 1'b0;
            res_valid_q <= 1'b0;
            out_q       <= '0;
            flags_q     <= '{c: 1'b0, v: 1'b0, z: 1'b1, n: 1'b0};
            illegal_q   <= 1'b0;
        end else begin
            if (load) begin
                out_q       <= nxt_res;
                flags_q     <= nxt_flags;
                illegal_q   <= nxt_ill;
                res_valid_q <= 1'b1;
                state       <= S_DONE;
            end
            case (state)
                S_IDLE: begin
                    if (accept) begin
                        in_ready_q <= 1'b0;
                        if (!load) begin
                            state <= S_SHIFT;
                        end
                    end else begin
                        in_ready_q <= 1'b1;
                    end
                end
                S_SHIFT: ;
                S_DONE: begin
                    if (res_ready_i) begin
                        state       <= S_IDLE;
                        res_valid_q <= 1'b0;
                        in_ready_q  <= 1'b1;
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    assign in_ready_o  = in_ready_q;
    assign res_valid_o = res_valid_q;
    assign out_o       = out_q;
    assign cflag_o     = flags_q.c;
    assign vflag_o     = flags_q.v;
    assign zflag_o     = flags_q.z;
    assign nflag_o     = flags_q.n;
    assign illegal_o   = illegal_q;

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq (XLEN=64); expected shift latencies follow ALU_SEQ_BARREL_EN.
module tb_alu_seq;

`ifdef ALU_SEQ_BARREL_EN
    localparam bit BARREL = 1'b1;
`else
    localparam bit BARREL = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  op;
    logic [63:0] a;
    logic [63:0] b;
    logic        cin;
    logic        res_valid;
    logic        res_ready;
    logic [63:0] out;
    logic        cflag, vflag, zflag, nflag;
    logic        illegal;
    logic [3:0]  flags;

    int checks = 0;
    int errors = 0;

    assign flags = {cflag, vflag, zflag, nflag};

    always #5 clk = ~clk;

    alu_seq #(.XLEN(64)) dut (
        .clk_i       (clk),
        .rst_ni      (rst_n),
        .in_valid_i  (in_valid),
        .in_ready_o  (in_ready),
        .op_i        (op),
        .a_i         (a),
        .b_i         (b),
        .cflag_i     (cin),
        .res_valid_o (res_valid),
        .res_ready_i (res_ready),
        .out_o       (out),
        .cflag_o     (cflag),
        .vflag_o     (vflag),
        .zflag_o     (zflag),
        .nflag_o     (nflag),
        .illegal_o   (illegal)
    );

    // Issues one request, scrambles inputs after acceptance, returns cycles until res_valid.
    task automatic run_op(input logic [3:0] o, input logic [63:0] av, input logic [63:0] bv,
                          input logic ci, output int lat);
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        if (!in_ready) begin
            checks++; errors++;
            $display("FAIL run_op_ready: in_ready=%0b required 1", in_ready);
        end
        op = o; a = av; b = bv; cin = ci; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0; op = 4'd1; a = '1; b = 64'h5; cin = ~ci;
        lat = 1;
        @(negedge clk);
        while (!res_valid && lat < 200) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take;
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic test_reset;
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++;
        if (out !== 64'd0 || illegal !== 1'b0) begin
            errors++; $display("FAIL reset_out: out=%h illegal=%0b required 0/0", out, illegal);
        end
        checks++;
        if (flags !== 4'b0010) begin
            errors++; $display("FAIL reset_flags: cvzn=%b required 0010", flags);
        end
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL reset_hs: valid=%0b ready=%0b required 0/0", res_valid, in_ready);
        end
        rst_n = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++; $display("FAIL release_ready_early: in_ready=%0b required 0", in_ready);
        end
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++; $display("FAIL release_ready: in_ready=%0b required 1", in_ready);
        end
    endtask

    task automatic test_add;
        int lat;
        run_op(4'd0, 64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, lat);
        checks++;
        if (lat !== 1) begin errors++; $display("FAIL add_lat: got %0d required 1", lat); end
        checks++;
        if (out !== 64'h8000_0000_0000_0000) begin
            errors++; $display("FAIL add_out: got %h required 8000000000000000", out);
        end
        checks++;
        if (flags !== 4'b0101) begin errors++; $display("FAIL add_flags: cvzn=%b required 0101", flags); end
        checks++;
        if (in_ready !== 1'b0) begin errors++; $display("FAIL done_ready: got %0b required 0", in_ready); end
        take();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL add_release: valid=%0b ready=%0b required 0/1", res_valid, in_ready);
        end
    endtask

    task automatic test_sub;
        int lat;
        run_op(4'd1, 64'd5, 64'd5, 1'b0, lat);
        checks++;
        if (out !== 64'd0 || flags !== 4'b1010) begin
            errors++; $display("FAIL sub: out=%h cvzn=%b required 0/1010", out, flags);
        end
        take();
    endtask

    task automatic test_carry_ops;
        int lat;
        run_op(4'd3, 64'd0, 64'd0, 1'b0, lat);
        checks++;
        if (out !== 64'hFFFF_FFFF_FFFF_FFFF || flags !== 4'b0001) begin
            errors++; $display("FAIL sbc: out=%h cvzn=%b required ffffffffffffffff/0001", out, flags);
        end
        take();
        run_op(4'd2, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b1, lat);
        checks++;
        if (out !== 64'd0 || flags !== 4'b1010) begin
            errors++; $display("FAIL adc: out=%h cvzn=%b required 0/1010", out, flags);
        end
        take();
    endtask

    task automatic test_logic;
        int lat;
        logic [63:0] exp_out [4];
        logic [3:0]  exp_fl  [4];
        logic [3:0]  ops     [4];
        logic [63:0] bs      [4];
        ops = '{4'd4, 4'd5, 4'd6, 4'd6};
        bs  = '{64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00, 64'hFF00_FF00_FF00_FF00, 64'hF0F0_F0F0_F0F0_F0F0};
        exp_out = '{64'hF000_F000_F000_F000, 64'hFFF0_FFF0_FFF0_FFF0, 64'h0FF0_0FF0_0FF0_0FF0, 64'd0};
        exp_fl  = '{4'b0001, 4'b0001, 4'b0000, 4'b0010};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], 64'hF0F0_F0F0_F0F0_F0F0, bs[i], 1'b1, lat);
            checks++;
            if (out !== exp_out[i] || flags !== exp_fl[i] || lat !== 1) begin
                errors++;
                $display("FAIL logic_%0d: out=%h cvzn=%b lat=%0d required %h/%b/1", i, out, flags, lat, exp_out[i], exp_fl[i]);
            end
            take();
        end
    endtask

    task automatic test_shift;
        int lat;
        logic [3:0]  ops  [4];
        logic [63:0] as   [4];
        logic [63:0] bs   [4];
        logic [63:0] eout [4];
        logic [3:0]  efl  [4];
        int          elat [4];
        ops  = '{4'd9, 4'd7, 4'd7, 4'd8};
        as   = '{64'h8000_0000_0000_0000, 64'h1234, 64'hF000_0000_0000_0001, 64'h84};
        bs   = '{64'd63, 64'h40, 64'd4, 64'd67};
        eout = '{64'hFFFF_FFFF_FFFF_FFFF, 64'h1234, 64'h10, 64'h10};
        efl  = '{4'b0001, 4'b0000, 4'b1000, 4'b1000};
        elat = '{BARREL ? 1 : 64, 1, BARREL ? 1 : 5, BARREL ? 1 : 4};
        for (int i = 0; i < 4; i++) begin
            run_op(ops[i], as[i], bs[i], 1'b1, lat);
            checks++;
            if (out !== eout[i] || flags !== efl[i]) begin
                errors++;
                $display("FAIL shift_%0d: out=%h cvzn=%b required %h/%b", i, out, flags, eout[i], efl[i]);
            end
            checks++;
            if (lat !== elat[i]) begin
                errors++; $display("FAIL shift_lat_%0d: got %0d required %0d", i, lat, elat[i]);
            end
            take();
        end
    endtask

    task automatic test_illegal;
        int lat;
        run_op(4'd12, 64'd5, 64'd6, 1'b1, lat);
        checks++;
        if (out !== 64'd0 || illegal !== 1'b1 || flags !== 4'b0010 || lat !== 1) begin
            errors++;
            $display("FAIL illegal: out=%h ill=%0b cvzn=%b lat=%0d required 0/1/0010/1", out, illegal, flags, lat);
        end
        take();
        run_op(4'd0, 64'd1, 64'd1, 1'b0, lat);
        checks++;
        if (out !== 64'd2 || illegal !== 1'b0) begin
            errors++; $display("FAIL illegal_clear: out=%h ill=%0b required 2/0", out, illegal);
        end
        take();
    endtask

    task automatic test_backpressure;
        int lat;
        run_op(4'd0, 64'd1, 64'd2, 1'b0, lat);
        op = 4'd1; a = 64'd100; b = 64'd1; in_valid = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (out !== 64'd3 || res_valid !== 1'b1 || in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_%0d: out=%h valid=%0b ready=%0b required 3/1/0", i, out, res_valid, in_ready);
            end
        end
        in_valid = 1'b0;
        take();
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL hold_release: valid=%0b ready=%0b required 0/1", res_valid, in_ready);
        end
        repeat (3) @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || out !== 64'd3) begin
            errors++; $display("FAIL hold_ignored: valid=%0b out=%h required 0/3", res_valid, out);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        res_ready = 1'b1;
        op = 4'd0; a = 64'd10; b = 64'd20; cin = 1'b0; in_valid = 1'b1;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b1 || out !== 64'd30 || in_ready !== 1'b0) begin
            errors++; $display("FAIL b2b_first: valid=%0b out=%h ready=%0b required 1/30/0", res_valid, out, in_ready);
        end
        op = 4'd1; a = 64'd50; b = 64'd8;
        @(negedge clk);
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_gap: valid=%0b ready=%0b required 0/1", res_valid, in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        checks++;
        if (res_valid !== 1'b1 || out !== 64'd42) begin
            errors++; $display("FAIL b2b_second: valid=%0b out=%h required 1/42", res_valid, out);
        end
        @(negedge clk);
        res_ready = 1'b0;
        checks++;
        if (res_valid !== 1'b0) begin
            errors++; $display("FAIL b2b_drain: valid=%0b required 0", res_valid);
        end
    endtask

    task automatic test_reset_mid_shift;
        int seen;
        int g;
        g = 0;
        @(negedge clk);
        while (!in_ready && g < 50) begin
            @(negedge clk);
            g++;
        end
        op = 4'd7; a = 64'd1; b = 64'd40; cin = 1'b0; in_valid = 1'b1;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        repeat (19) @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (out !== 64'd0 || flags !== 4'b0010 || illegal !== 1'b0) begin
            errors++; $display("FAIL abort_out: out=%h cvzn=%b ill=%0b required 0/0010/0", out, flags, illegal);
        end
        checks++;
        if (res_valid !== 1'b0 || in_ready !== 1'b0) begin
            errors++; $display("FAIL abort_hs: valid=%0b ready=%0b required 0/0", res_valid, in_ready);
        end
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        seen = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge clk);
            if (res_valid) seen++;
        end
        checks++;
        if (seen !== 0 || in_ready !== 1'b1) begin
            errors++; $display("FAIL abort_discard: valid cycles=%0d ready=%0b required 0/1", seen, in_ready);
        end
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; res_ready = 1'b0;
        op = 4'd0; a = '0; b = '0; cin = 1'b0;
        test_reset();
        test_add();
        test_sub();
        test_carry_ops();
        test_logic();
        test_shift();
        test_illegal();
        test_backpressure();
        test_back_to_back();
        test_reset_mid_shift();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
